testcore_nios2_dbg_ocimem_ctrl: RTL

//  On-chip-instrumentation memory controller for the Nios II JTAG debug path. Sits directly

---
 rtl/testcore_nios2_dbg_pkg.sv | 31 +++
 rtl/testcore_nios2_dbg_ocimem_ram.sv | 42 ++++
 rtl/testcore_nios2_dbg_ocimem_ctrl.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/testcore_nios2_dbg_pkg.sv
// Shared definitions for the Nios II debug on-chip-instrumentation memory path.
// Holds the jdo field positions, the monitor address width, the CPU-port FSM
// state encoding, and the wrapping monitor-address increment helper.
package testcore_nios2_dbg_pkg;

  localparam int JDO_W          = 38;
  localparam int JDO_ADDR_MSB   = 34;  // ocimem_a: word address
  localparam int JDO_ADDR_LSB   = 26;
  localparam int JDO_RD_REQ     = 25;  // ocimem_a: also read the word
  localparam int JDO_CLR_STATUS = 24;  // ocimem_a: clear ready/error
  localparam int JDO_WDATA_MSB  = 34;  // ocimem_b: write data
  localparam int JDO_WDATA_LSB  = 3;

  localparam int MON_AW = 9;

  typedef enum logic [0:0] {
    CPU_IDLE = 1'b0,
    CPU_RD   = 1'b1
  } cpu_state_t;

  // Next monitor address: wraps from the last RAM word back to 0 silently.
  function automatic logic [MON_AW-1:0] mon_addr_inc(input logic [MON_AW-1:0] addr,
                                                    input int depth);
    if ({23'd0, addr} == 32'(depth - 1)) begin
      return '0;
    end else begin
      return addr + 9'd1;
    end
  endfunction

endpackage

// File: rtl/testcore_nios2_dbg_ocimem_ram.sv
// Single-port synchronous debug RAM, 32-bit words with byte enables.
// One-clock read latency; a read that hits the word being written returns the
// old contents. Contents are not affected by reset.
// Ports:
//   clk    in   clock
//   en     in   port access enable (read always happens when enabled)
//   be     in   4 byte write enables (all zero = pure read)
//   addr   in   AW word address
//   wdata  in   32 write data
//   q      out  32 registered read data
module testcore_nios2_dbg_ocimem_ram #(
  parameter int    DEPTH = 256,
  parameter string INIT  = "",
  parameter int    AW    = 8
) (
  input  logic          clk,
  input  logic          en,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   q
);

  // Preload of the array is applied by the device implementation flow from INIT;
  // the name is referenced here so it remains part of the interface.
  localparam bit unused_init = (INIT != "");

  logic [31:0] mem [DEPTH];

  // Byte-enabled write and registered read-before-write of the addressed word.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
      q <= mem[addr];
    end
  end

endmodule

// File: rtl/testcore_nios2_dbg_ocimem_ctrl.sv
// OCI memory controller for the Nios II JTAG debug path.
// Executes debugger word reads/writes from the sysclk decoder pulses into the
// debug RAM, returns MonDReg/monitor_ready/monitor_error, and shares the same
// RAM port with a CPU Avalon-MM slave. JTAG pulses always own the port.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   jdo[37:0]                   decoder data, valid while a take_* pulse is high
//   take_action_ocimem_a        load address (+ optional read, clear status)
//   take_action_ocimem_b        write word at MonAReg
//   take_no_action_ocimem_a     read word at MonAReg
//   avs_*                       CPU slave port (address, read, write, data,
//                               byteenable, debugaccess, readdata, waitrequest)
//   MonDReg, MonAReg            monitor data / word address registers
//   monitor_ready, monitor_error  read-data valid, sticky out-of-range flag
module testcore_nios2_dbg_ocimem_ctrl
  import testcore_nios2_dbg_pkg::*;
#(
  parameter int    DEPTH = 256,
  parameter string INIT  = "",
  localparam int   AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [JDO_W-1:0]  jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic [AW-1:0]     avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  input  logic [3:0]        avs_byteenable,
  input  logic              avs_debugaccess,
  output logic [31:0]       avs_readdata,
  output logic              avs_waitrequest,
  output logic [31:0]       MonDReg,
  output logic [MON_AW-1:0] MonAReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  localparam logic [MON_AW:0] DEPTH_LIM = 10'(DEPTH);

  logic [MON_AW-1:0] jdo_addr;
  logic [31:0]       jdo_wdata;
  logic              rd_req;
  logic              clr_status;
  logic              unused_jdo;

  assign jdo_addr   = jdo[JDO_ADDR_MSB:JDO_ADDR_LSB];
  assign jdo_wdata  = jdo[JDO_WDATA_MSB:JDO_WDATA_LSB];
  assign rd_req     = jdo[JDO_RD_REQ];
  assign clr_status = jdo[JDO_CLR_STATUS];
  assign unused_jdo = ^{jdo[37:35], jdo[2:0]};

  // Pulse priority is a > b > no_action; a simultaneous b is dropped.
  logic              jtag_act;
  logic              j_rd;
  logic              j_wr;
  logic [MON_AW-1:0] j_addr;
  logic              j_inrange;

  assign jtag_act  = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
  assign j_wr      = take_action_ocimem_b & ~take_action_ocimem_a;
  assign j_rd      = (take_action_ocimem_a & rd_req)
                   | (take_no_action_ocimem_a & ~take_action_ocimem_a & ~take_action_ocimem_b);
  assign j_addr    = take_action_ocimem_a ? jdo_addr : MonAReg;
  assign j_inrange = ({1'b0, j_addr} < DEPTH_LIM);

  cpu_state_t  state;
  logic        jrd_pend;
  logic        jrd_oor;
  logic        ram_en;
  logic [3:0]  ram_be;
  logic [AW-1:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_q;

  testcore_nios2_dbg_ocimem_ram #(
    .DEPTH (DEPTH),
    .INIT  (INIT),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .be    (ram_be),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .q     (ram_q)
  );

  // RAM port mux: JTAG first, then CPU (only from IDLE). Out-of-range JTAG
  // accesses and non-debug CPU writes never touch the array.
  always_comb begin
    ram_en    = 1'b0;
    ram_be    = 4'h0;
    ram_addr  = avs_address;
    ram_wdata = avs_writedata;
    if (jtag_act) begin
      ram_addr  = j_addr[AW-1:0];
      ram_wdata = jdo_wdata;
      if ((j_rd || j_wr) && j_inrange) begin
        ram_en = 1'b1;
        ram_be = j_wr ? 4'hF : 4'h0;
      end else begin
        ram_en = 1'b0;
      end
    end else if (state == CPU_IDLE && avs_read) begin
      ram_en = 1'b1;
    end else if (state == CPU_IDLE && avs_write && avs_debugaccess) begin
      ram_en = 1'b1;
      ram_be = avs_byteenable;
    end else begin
      ram_en = 1'b0;
    end
  end

  // CPU port FSM: a read takes one RAM cycle then returns data in CPU_RD.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= CPU_IDLE;
    end else begin
      case (state)
        CPU_IDLE: if (avs_read && !jtag_act) state <= CPU_RD;
        CPU_RD:   state <= CPU_IDLE;
        default:  state <= CPU_IDLE;
      endcase
    end
  end

  // Stall reads until data is ready; stall writes only while JTAG owns the port.
  always_comb begin
    case (state)
      CPU_IDLE: avs_waitrequest = avs_read | (avs_write & jtag_act);
      CPU_RD:   avs_waitrequest = 1'b0;
      default:  avs_waitrequest = 1'b0;
    endcase
  end

  assign avs_readdata = (state == CPU_RD) ? ram_q : 32'h0;

  // JTAG monitor registers. Status clear is applied before any set on the same
  // edge so a completing or out-of-range access still reports.
  always_ff @(posedge clk) begin
    if (reset) begin
      MonDReg       <= 32'h0;
      MonAReg       <= '0;
      monitor_ready <= 1'b0;
      monitor_error <= 1'b0;
      jrd_pend      <= 1'b0;
      jrd_oor       <= 1'b0;
    end else begin
      if (take_action_ocimem_a && clr_status) begin
        monitor_ready <= 1'b0;
        monitor_error <= 1'b0;
      end
      if (take_action_ocimem_a) begin
        MonAReg <= jdo_addr;
      end
      if (jrd_pend) begin
        monitor_ready <= 1'b1;
        if (!jrd_oor) begin
          MonDReg <= ram_q;
        end
      end
      if (j_rd || j_wr) begin
        MonAReg <= mon_addr_inc(j_addr, DEPTH);
        if (!j_inrange) begin
          monitor_error <= 1'b1;
        end else if (j_wr) begin
          MonDReg <= jdo_wdata;
        end
      end
      jrd_pend <= j_rd;
      jrd_oor  <= j_rd & ~j_inrange;
    end
  end

endmodule
